// File: rtl/read_master_pkg.sv
// Shared encodings and helpers for the AXI read master.
package read_master_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] SIZE_1B = 2'b00;
  localparam logic [1:0] SIZE_2B = 2'b01;
  localparam logic [1:0] SIZE_4B = 2'b10;

  localparam int unsigned MAX_ARLEN = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // The downstream slave never serves more than MAX_ARLEN+1 beats.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > 4'(MAX_ARLEN)) ? 4'(MAX_ARLEN) : len;
  endfunction

  // Sizes wider than the 32-bit bus are folded back to 4 bytes.
  function automatic logic [1:0] legal_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_4B : size;
  endfunction

endpackage

// File: rtl/resp_fifo.sv
// Circular response buffer; the head entry reads as zero while empty.
module resp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   push,
  input  logic                   pop,
  input  logic [Width-1:0]       wdata,
  output logic [Width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      cnt <= cnt + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign full  = (cnt == CntW'(Depth));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/read_master.sv
// Single-outstanding AXI read master with a response buffer toward the host.
// Define READ_MASTER_CHECK_EN to flag ID and burst-length protocol errors per beat.
module read_master
  import read_master_pkg::*;
#(
  parameter int unsigned BusWidth = 32,
  parameter int unsigned tagbits  = 2,
  parameter int unsigned BufDepth = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [tagbits-1:0]  req_id,
  input  logic [BusWidth-1:0] req_addr,
  input  logic [3:0]          req_len,
  input  logic [1:0]          req_size,
  input  logic [1:0]          req_burst,
  output logic [tagbits-1:0]  ARID,
  output logic [BusWidth-1:0] ARADDR,
  output logic [3:0]          ARLEN,
  output logic [1:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic [1:0]          ARLOCK,
  output logic [3:0]          ARCACHE,
  output logic [2:0]          ARPROT,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [tagbits-1:0]  RID,
  input  logic [BusWidth-1:0] RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  output logic [BusWidth-1:0] rd_data,
  output logic [tagbits-1:0]  rd_id,
  output logic                rd_last,
  output logic                rd_err,
  output logic                rd_valid,
  input  logic                rd_ready
);

  localparam int unsigned EntryW = BusWidth + tagbits + 2;
  localparam int unsigned CntW   = $clog2(BufDepth) + 1;

  state_e            state_q;
  state_e            state_d;
  logic              req_hs;
  logic              ar_hs;
  logic              r_push;
  logic              rd_pop;
  logic              beat_err;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic [CntW-1:0]   count_nx;
  logic              full_nx;
  logic [EntryW-1:0] fifo_rdata;

  assign req_hs = req_valid && req_ready;
  assign ar_hs  = ARVALID && ARREADY;
  assign r_push = RVALID && RREADY && !fifo_full;
  assign rd_pop = rd_valid && rd_ready;

  assign ARLOCK  = '0;
  assign ARCACHE = '0;
  assign ARPROT  = '0;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_hs)           state_d = ST_ADDR;
      ST_ADDR: if (ar_hs)            state_d = ST_DATA;
      ST_DATA: if (r_push && RLAST)  state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Buffer occupancy after this edge, so RREADY drops right after the filling push.
  always_comb begin
    count_nx = fifo_count + CntW'(r_push) - CntW'(rd_pop);
    full_nx  = (count_nx == CntW'(BufDepth));
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      req_ready <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      ARID      <= '0;
      ARADDR    <= '0;
      ARLEN     <= '0;
      ARSIZE    <= '0;
      ARBURST   <= '0;
    end else begin
      req_ready <= (state_d == ST_IDLE);
      ARVALID   <= (state_d == ST_ADDR);
      RREADY    <= (state_d == ST_DATA) && !full_nx;
      if (req_hs) begin
        ARID    <= req_id;
        ARADDR  <= req_addr;
        ARLEN   <= clamp_len(req_len);
        ARSIZE  <= legal_size(req_size);
        ARBURST <= req_burst;
      end
    end
  end

`ifdef READ_MASTER_CHECK_EN
  logic [2:0] beat_cnt;
  logic       unused_rresp;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)                          beat_cnt <= '0;
    else if (ar_hs)                      beat_cnt <= '0;
    else if (r_push && beat_cnt != 3'd7) beat_cnt <= beat_cnt + 3'd1;
  end

  // beat_cnt is the zero-based index of the beat currently on the R channel.
  assign beat_err = RRESP[1]
                  | (RID != ARID)
                  | (RLAST && ({1'b0, beat_cnt} != ARLEN))
                  | (!RLAST && ({1'b0, beat_cnt} > ARLEN));
  assign unused_rresp = RRESP[0];
`else
  logic unused_rresp;

  assign beat_err     = RRESP[1];
  assign unused_rresp = ^{RRESP[0], RID};
`endif

  resp_fifo #(
    .Width (EntryW),
    .Depth (BufDepth)
  ) u_resp_fifo (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .push   (r_push),
    .pop    (rd_pop),
    .wdata  ({RDATA, RID, RLAST, beat_err}),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign rd_valid = !fifo_empty;
  assign {rd_data, rd_id, rd_last, rd_err} = fifo_rdata;

endmodule
